// File: rtl/rv_pkg.sv
// Shared RV32 front-end constants: instruction layout, opcode groups and reset vector.
package rv_pkg;

  localparam int unsigned INST_W     = 32;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned OPCODE_MSB = 6;
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  // opcode[6:2] groups decoded by control_unit
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_REG    = 5'b01100;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INST_W-1:0] inst);
    return inst[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/ifetch_fifo2.sv
// Two-entry {instruction, pc} buffer between imem responses and decode.
// Flush wins over push and pop; entry 0 is always the head.
module ifetch_fifo2
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [INST_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_pc,
  output logic [INST_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_pc,
  output logic [1:0]        count
);

  logic [INST_W-1:0] data_q [2];
  logic [ADDR_W-1:0] pc_q   [2];
  logic              do_pop;
  logic              do_push;
  logic              wr_idx;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  // slot that is free once this cycle's pop has shifted the entries down
  assign wr_idx  = ((count - 2'(do_pop)) != 2'd0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= 2'd0;
    end else begin
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_pop) begin
      data_q[0] <= data_q[1];
      pc_q[0]   <= pc_q[1];
    end
    if (do_push) begin
      data_q[wr_idx] <= push_data;
      pc_q[wr_idx]   <= push_pc;
    end
  end

  assign head_data = data_q[0];
  assign head_pc   = pc_q[0];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: sequential PC generation, 1-cycle imem reads,
// 2-entry response buffer with valid/ready to decode, and redirect flushing.
module ifetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              misalign_err
);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              pending;
  logic              squash;
  logic [1:0]        count;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        credit_c;

  assign inst_valid = (count != 2'd0);
  assign pop        = inst_valid && inst_ready;

  // entries the buffer will hold once everything in flight has landed
  assign credit_c = 3'(count) + 3'(pending) - 3'(pop);
  assign issue    = !rst && !redirect_valid && (credit_c < 3'd2);
  assign push     = pending && !squash && !redirect_valid;

  assign imem_en   = issue;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      req_pc       <= RESET_PC;
      pending      <= 1'b0;
      squash       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      pending <= issue;
      squash  <= issue && redirect_valid;
      if (issue) begin
        req_pc <= fetch_pc;
      end
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) begin
          misalign_err <= 1'b1;
        end
      end else if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
    end
  end

  ifetch_fifo2 #(
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data (imem_rdata),
    .push_pc   (req_pc),
    .head_data (inst_data),
    .head_pc   (inst_pc),
    .count     (count)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboarded bench for ifetch_unit: expected PC stream per redirect/reset,
// imem model returning addr ^ A5A5_0000 one cycle after the request.
module tb_ifetch_unit;
  import rv_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        misalign_err;

  int          checks = 0;
  int          errors = 0;
  int          en_cnt;
  logic [31:0] expq [$];
  logic [31:0] nxt_pc;
  logic [31:0] sb_e;
  logic [31:0] exp_fetch = RST_PC;
  logic        exp_mis   = 1'b0;
  logic        hold_v    = 1'b0;
  logic [31:0] hold_pc;
  logic [31:0] hold_data;
  logic [31:0] rtgt;

  always #5 clk = ~clk;

  ifetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .misalign_err   (misalign_err)
  );

  // synchronous imem: garbage when not requested so stale data cannot pass
  always @(posedge clk) imem_rdata <= imem_en ? (imem_addr ^ KEY) : $urandom();

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic topup();
    while (expq.size() < 8) begin
      expq.push_back(nxt_pc);
      nxt_pc = nxt_pc + 32'd4;
    end
  endtask

  // new instruction stream starting at pc; older expectations are dead
  task automatic sb_reset(input logic [31:0] pc);
    expq.delete();
    nxt_pc = pc;
    topup();
  endtask

  always @(posedge clk) topup();

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // monitor: request addresses, delivered stream, hold under backpressure, sticky error
  always @(negedge clk) begin
    chkb("misalign_err", misalign_err, exp_mis);
    if (hold_v) begin
      chkb("hold_valid", inst_valid, 1'b1);
      chk("hold_pc", inst_pc, hold_pc);
      chk("hold_data", inst_data, hold_data);
    end
    if (rst) begin
      chkb("en_in_rst", imem_en, 1'b0);
      exp_fetch = RST_PC;
      exp_mis   = 1'b0;
    end else if (redirect_valid) begin
      chkb("en_in_redirect", imem_en, 1'b0);
      exp_fetch = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
    end else begin
      if (imem_en) begin
        chk("imem_addr", imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (inst_valid && inst_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty actual_pc=%h expected=<none> t=%0t", inst_pc, $time);
        end else begin
          sb_e = expq.pop_front();
          chk("inst_pc", inst_pc, sb_e);
          chk("inst_data", inst_data, sb_e ^ KEY);
        end
      end
    end
    hold_v    = inst_valid && !inst_ready && !redirect_valid && !rst;
    hold_pc   = inst_pc;
    hold_data = inst_data;
  end

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = 1'b1;
    sb_reset(RST_PC);
    repeat (3) cyc();

    // reset release: first request immediately, first valid two cycles later
    rst = 1'b0;
    sb_reset(RST_PC);
    @(negedge clk);
    chkb("c0_en", imem_en, 1'b1);
    chk("c0_addr", imem_addr, 32'h0);
    chkb("c0_valid", inst_valid, 1'b0);
    @(negedge clk);
    chkb("c1_valid", inst_valid, 1'b0);
    chk("c1_addr", imem_addr, 32'h4);

    // stall right at the first valid: two outstanding, no further issue
    cyc();
    inst_ready = 1'b0;
    en_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      chkb("stall_valid", inst_valid, 1'b1);
      if (imem_en) en_cnt++;
    end
    chk("stall_en_cnt", 32'(en_cnt), 32'd0);
    chk("stall_pc", inst_pc, 32'h0);
    chk("stall_data", inst_data, KEY);
    cyc();
    inst_ready = 1'b1;
    repeat (10) cyc();

    // fill the buffer, then redirect to 0x100
    inst_ready = 1'b0;
    repeat (3) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    inst_ready = 1'b1;
    sb_reset(32'h100);
    @(negedge clk);
    chkb("r0_en", imem_en, 1'b0);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chkb("r1_valid", inst_valid, 1'b0);
    chkb("r1_en", imem_en, 1'b1);
    chk("r1_addr", imem_addr, 32'h100);
    @(negedge clk);
    chkb("r2_valid", inst_valid, 1'b0);
    @(negedge clk);
    chkb("r3_valid", inst_valid, 1'b1);
    chk("r3_pc", inst_pc, 32'h100);
    repeat (6) cyc();

    // back-to-back redirects: last one wins
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    sb_reset(32'h40);
    cyc();
    redirect_pc = 32'h80;
    sb_reset(32'h80);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("bb_addr", imem_addr, 32'h80);
    chkb("bb_valid0", inst_valid, 1'b0);
    @(negedge clk);
    chkb("bb_valid1", inst_valid, 1'b0);
    @(negedge clk);
    chkb("bb_valid2", inst_valid, 1'b1);
    chk("bb_pc", inst_pc, 32'h80);

    // misaligned target
    repeat (4) cyc();
    chkb("mis_before", misalign_err, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    sb_reset(32'h100);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chkb("mis_set", misalign_err, 1'b1);
    chk("mis_addr", imem_addr, 32'h100);
    repeat (2) @(negedge clk);
    chkb("mis_valid", inst_valid, 1'b1);
    chk("mis_pc", inst_pc, 32'h100);

    // random backpressure and redirects
    for (int i = 0; i < 400; i++) begin
      cyc();
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        rtgt = ($urandom_range(0, 1023) << 2) | (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = rtgt;
        sb_reset({rtgt[31:2], 2'b00});
      end else begin
        redirect_valid = 1'b0;
      end
    end
    cyc();
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    repeat (8) cyc();
    chkb("mis_sticky", misalign_err, 1'b1);
    chkb("pre_rst_valid", inst_valid, 1'b1);

    // reset mid-stream, then restart under backpressure
    rst = 1'b1;
    @(negedge clk);
    chkb("rst_en", imem_en, 1'b0);
    cyc();
    @(negedge clk);
    chkb("rst_valid", inst_valid, 1'b0);
    cyc();
    rst = 1'b0;
    inst_ready = 1'b0;
    sb_reset(RST_PC);
    en_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (imem_en) en_cnt++;
    end
    chk("bp_issue_cnt", 32'(en_cnt), 32'd2);
    chk("bp_pc", inst_pc, RST_PC);
    cyc();
    inst_ready = 1'b1;
    repeat (6) cyc();
    chkb("mis_cleared", misalign_err, 1'b0);

    // address wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    sb_reset(32'hFFFF_FFFC);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_a0", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chkb("wrap_en1", imem_en, 1'b1);
    chk("wrap_a1", imem_addr, 32'h0);
    @(negedge clk);
    chkb("wrap_valid", inst_valid, 1'b1);
    chk("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_pc1", inst_pc, 32'h0);
    repeat (5) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
